// File: rtl/nes_bus_pkg.sv
// CPU-bus constants and DMA state encoding shared by the sprite DMA and bus decode.
package nes_bus_pkg;

  localparam logic [15:0] PPU_REG_BASE = 16'h2000;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam int          BYTE_COUNT   = 256;
  localparam int          CNT_W        = $clog2(BYTE_COUNT) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 halts the CPU and copies page $XX00-$XXFF into OAMDATA.
//
// state | meaning
// IDLE  | CPU owns the bus, waiting for a $4014 write
// HALT  | CPU halted, bus repeats the trigger address as a read
// ALIGN | dummy read so the first READ lands on an even (get) cycle
// READ  | get cycle: read {page, idx}, capture mem_d_in on close
// WRITE | put cycle: write captured byte to OAMDATA, advance idx
// DONE  | CPU released for one cycle before returning to IDLE
module oam_dma
  import nes_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cycle_en,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  mem_d_in,
  output logic        cpu_rdy_out,
  output logic        dma_active_out,
  output logic [15:0] bus_addr_out,
  output logic        bus_r_nw_out,
  output logic [7:0]  bus_d_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTE_COUNT - 1);

  dma_state_e       state_q, state_d;
  logic             parity_q;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       page_q, page_d;

  logic        rdy_d, active_d, r_nw_d;
  logic [15:0] addr_d;
  logic [7:0]  data_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    page_d   = page_q;
    rdy_d    = 1'b1;
    active_d = 1'b0;
    r_nw_d   = 1'b1;
    addr_d   = '0;
    data_d   = '0;

    case (state_q)
      IDLE: begin
        if (cpu_addr_in == DMA_REG_ADDR && !cpu_r_nw_in) begin
          state_d = HALT;
          page_d  = cpu_d_in;
          idx_d   = '0;
        end
      end
      // parity_q is the current cycle's parity; an even HALT would put READ on an odd cycle
      HALT:    state_d = parity_q ? READ : ALIGN;
      ALIGN:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE: begin
        idx_d   = idx_q + CNT_W'(1);
        state_d = (idx_q < LAST_IDX) ? READ : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the cycle being entered and registered on the enable edge.
    case (state_d)
      HALT: begin
        rdy_d    = 1'b0;
        active_d = 1'b1;
        addr_d   = cpu_addr_in;
      end
      ALIGN: begin
        rdy_d    = 1'b0;
        active_d = 1'b1;
        addr_d   = bus_addr_out;
      end
      READ: begin
        rdy_d    = 1'b0;
        active_d = 1'b1;
        addr_d   = {page_d, idx_d[7:0]};
      end
      WRITE: begin
        rdy_d    = 1'b0;
        active_d = 1'b1;
        r_nw_d   = 1'b0;
        addr_d   = OAMDATA_ADDR;
        data_d   = mem_d_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      parity_q       <= 1'b0;
      idx_q          <= '0;
      page_q         <= '0;
      cpu_rdy_out    <= 1'b1;
      dma_active_out <= 1'b0;
      bus_addr_out   <= '0;
      bus_r_nw_out   <= 1'b1;
      bus_d_out      <= '0;
    end else if (cpu_cycle_en) begin
      state_q        <= state_d;
      parity_q       <= ~parity_q;
      idx_q          <= idx_d;
      page_q         <= page_d;
      cpu_rdy_out    <= rdy_d;
      dma_active_out <= active_d;
      bus_addr_out   <= addr_d;
      bus_r_nw_out   <= r_nw_d;
      bus_d_out      <= data_d;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: idle vector table plus modelled full/aborted/stretched transfers.
module tb_oam_dma;

  localparam logic [26:0] IDLE_OUT = {1'b1, 1'b0, 1'b1, 16'h0000, 8'h00};

  logic        clk = 1'b0;
  logic        rst, cpu_cycle_en, cpu_r_nw_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_d_in, mem_d_in;
  logic        cpu_rdy_out, dma_active_out, bus_r_nw_out;
  logic [15:0] bus_addr_out;
  logic [7:0]  bus_d_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mem_mode = 0;
  logic [7:0] mem_rand [256];

  always #5 clk = ~clk;

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_cycle_en(cpu_cycle_en),
    .cpu_addr_in(cpu_addr_in), .cpu_r_nw_in(cpu_r_nw_in), .cpu_d_in(cpu_d_in),
    .mem_d_in(mem_d_in), .cpu_rdy_out(cpu_rdy_out), .dma_active_out(dma_active_out),
    .bus_addr_out(bus_addr_out), .bus_r_nw_out(bus_r_nw_out), .bus_d_out(bus_d_out)
  );

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    case (mem_mode)
      0:       return a[7:0];
      1:       return ~a[7:0];
      default: return mem_rand[a[7:0]] ^ a[15:8];
    endcase
  endfunction

  // Memory answers whatever address the DMA currently drives.
  always_comb begin
    case (mem_mode)
      0:       mem_d_in = bus_addr_out[7:0];
      1:       mem_d_in = ~bus_addr_out[7:0];
      default: mem_d_in = mem_rand[bus_addr_out[7:0]] ^ bus_addr_out[15:8];
    endcase
  end

  function automatic logic [26:0] outs();
    return {cpu_rdy_out, dma_active_out, bus_r_nw_out, bus_addr_out, bus_d_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cpu cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One CPU cycle: enable pulse with given inputs, then stretch-1 idle clocks with hostile inputs.
  task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d, input int stretch);
    logic [26:0] snap;
    cpu_addr_in = a; cpu_r_nw_in = rnw; cpu_d_in = d; cpu_cycle_en = 1'b1;
    @(posedge clk); #1;
    cpu_cycle_en = 1'b0;
    cyc++;
    snap = outs();
    for (int s = 1; s < stretch; s++) begin
      cpu_addr_in = 16'h4014; cpu_r_nw_in = 1'b0; cpu_d_in = 8'($urandom);
      @(posedge clk); #1;
      check("hold_between_enables", outs(), snap);
    end
  endtask

  // Expected outputs for cycle j of a transfer (j=1 is the cycle after the trigger write).
  function automatic logic [26:0] exp_out(input int j, input int al, input logic [7:0] page);
    int k;
    k = j - 2 - al;
    if (j == 1 || (j == 2 && al == 1)) return {1'b0, 1'b1, 1'b1, 16'h4014, 8'h00};
    if (k >= 0 && k < 512) begin
      if (k % 2 == 0) return {1'b0, 1'b1, 1'b1, page, 8'(k / 2), 8'h00};
      return {1'b0, 1'b1, 1'b0, 16'h2004, mem_val({page, 8'(k / 2)})};
    end
    return IDLE_OUT;
  endfunction

  task automatic run_dma(input logic [7:0] page, input int stretch, input int abort_k);
    int al, halted, writes, last;
    bit aborted;
    halted = 0; writes = 0; aborted = 0;
    cpu_cycle(16'h4014, 1'b0, page, stretch);
    // Parity counts enables since reset; an even HALT cycle needs an alignment cycle.
    al = (cyc % 2 == 0) ? 1 : 0;
    last = 514 + al;
    for (int j = 1; j <= last; j++) begin
      check("dma_cycle", outs(), exp_out(j, al, page));
      if (!cpu_rdy_out) halted++;
      if (dma_active_out && !bus_r_nw_out && bus_addr_out == 16'h2004) writes++;
      if (abort_k >= 0 && j - 2 - al == abort_k) begin
        aborted = 1;
        break;
      end
      if (j == last)
        cpu_cycle(16'h4014, 1'b0, 8'($urandom), stretch);
      else if ($urandom_range(0, 1) == 1)
        cpu_cycle(16'h4014, 1'b0, 8'($urandom), stretch);
      else
        cpu_cycle(16'($urandom), 1'($urandom), 8'($urandom), stretch);
    end
    if (aborted) begin
      rst = 1'b1; cpu_cycle_en = 1'($urandom);
      @(posedge clk); #1;
      rst = 1'b0; cpu_cycle_en = 1'b0; cyc = 0;
      check("reset_mid_transfer", outs(), IDLE_OUT);
    end else begin
      check("idle_after_done", outs(), IDLE_OUT);
      check("halted_cycles", halted, 513 + al);
      check("write_count", writes, 256);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  d;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"read_4014",  16'h4014, 1'b1, 8'h02, IDLE_OUT};
    vecs[1] = '{"write_4015", 16'h4015, 1'b0, 8'h02, IDLE_OUT};
    vecs[2] = '{"write_4013", 16'h4013, 1'b0, 8'h03, IDLE_OUT};
    vecs[3] = '{"write_2004", 16'h2004, 1'b0, 8'h55, IDLE_OUT};
    vecs[4] = '{"write_c014", 16'hC014, 1'b0, 8'h02, IDLE_OUT};
    vecs[5] = '{"write_0014", 16'h0014, 1'b0, 8'h02, IDLE_OUT};
    foreach (mem_rand[i]) mem_rand[i] = 8'($urandom);

    rst = 1'b1; cpu_cycle_en = 1'b1;
    cpu_addr_in = 16'h4014; cpu_r_nw_in = 1'b0; cpu_d_in = 8'h02;
    @(posedge clk); #1;
    check("reset_state", outs(), IDLE_OUT);
    rst = 1'b0; cpu_cycle_en = 1'b0; cyc = 0;

    for (int i = 0; i < 6; i++) begin
      cpu_cycle(vecs[i].addr, vecs[i].rnw, vecs[i].d, 1);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Trigger on even count so HALT is odd: no ALIGN, identity memory.
    mem_mode = 0;
    if (cyc % 2 == 1) cpu_cycle(16'h0000, 1'b1, 8'h00, 1);
    run_dma(8'h02, 1, -1);

    // One cycle later: ALIGN inserted.
    if (cyc % 2 == 0) cpu_cycle(16'h0000, 1'b1, 8'h00, 1);
    run_dma(8'h02, 1, -1);

    // Page $FF with inverted data: last read $FFFF, last write $00.
    mem_mode = 1;
    run_dma(8'hFF, 1, -1);

    // Reset during byte 100, then a fresh transfer from idx 0.
    mem_mode = 2;
    run_dma(8'($urandom), 1, 200);
    run_dma(8'h5A, 1, -1);

    // Slow enable: one CPU cycle per 12 clocks.
    run_dma(8'h03, 12, -1);

    for (int r = 0; r < 3; r++) begin
      if ($urandom_range(0, 1) == 1) cpu_cycle(16'($urandom), 1'b1, 8'h00, 1);
      run_dma(8'($urandom), $urandom_range(1, 3), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
